// File: rtl/uart_tx_arb_if.sv
// Signal bundle between the byte producers (master) and the shared UART arbiter (slave).
interface uart_tx_arb_if #(
   parameter int N_REQ = 4
);
   // Handshake: req[i] is a level held with req_data byte i stable until ack[i] pulses for one
   // cycle; the byte is then on uart_din with a coincident uart_en strobe toward uart_send.
   logic [N_REQ-1:0]   req;
   logic [8*N_REQ-1:0] req_data;
   logic [N_REQ-1:0]   ack;
   logic               uart_en;
   logic [7:0]         uart_din;
   logic               busy;
   logic               dbg_state;

   modport master (
      output req, req_data,
      input  ack, uart_en, uart_din, busy, dbg_state
   );

   modport slave (
      input  req, req_data,
      output ack, uart_en, uart_din, busy, dbg_state
   );
endinterface

// File: rtl/uart_tx_arb.sv
// Grants one of N_REQ byte sources to a shared uart_send, then idles for one frame plus guard.
// Define UART_ARB_FIXED_PRIO_EN for lowest-index-wins priority instead of round-robin.
module uart_tx_arb #(
   parameter int N_REQ     = 4,
   parameter int CLK_FREQ  = 50000000,
   parameter int UART_BPS  = 115200,
   parameter int GUARD_CYC = 16
) (
   input  logic         sys_clk,
   input  logic         sys_rst,
   uart_tx_arb_if.slave arb
);
   localparam int BPS_CNT   = CLK_FREQ / UART_BPS;
   localparam int FRAME_CYC = 10 * BPS_CNT;
   localparam int HOLD_CYC  = FRAME_CYC + GUARD_CYC;
   localparam int CNT_W     = $clog2(HOLD_CYC + 1);
   localparam int PTR_W     = $clog2(N_REQ);

   typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [PTR_W-1:0] win;
   logic             grant;
   logic             en_d;
   logic [N_REQ-1:0] ack_d;
   logic [7:0]       din_d;

   assign grant = (state_q == S_IDLE) && (arb.req != '0);

`ifdef UART_ARB_FIXED_PRIO_EN
   always_comb begin
      win = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (arb.req[i]) win = PTR_W'(i);
      end
   end
`else
   logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
   logic [PTR_W-1:0] cand;
   logic             found;

   // Scan upward from rr_ptr with wrap; first set request wins.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int off = 0; off < N_REQ; off++) begin
         cand = PTR_W'((int'(rr_ptr) + off) % N_REQ);
         if (!found && arb.req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr;
      if (grant) rr_ptr_d = PTR_W'((int'(win) + 1) % N_REQ);
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) rr_ptr <= '0;
      else         rr_ptr <= rr_ptr_d;
   end
`endif

   // State register; the handoff outputs are registered alongside it.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         arb.uart_en  <= 1'b0;
         arb.ack      <= '0;
         arb.uart_din <= 8'h00;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         arb.uart_en  <= en_d;
         arb.ack      <= ack_d;
         arb.uart_din <= din_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (grant) begin
               state_d = S_HOLD;
               cnt_d   = '0;
            end
         end
         S_HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(HOLD_CYC - 1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      en_d  = 1'b0;
      ack_d = '0;
      din_d = arb.uart_din;
      if (grant) begin
         en_d       = 1'b1;
         ack_d[win] = 1'b1;
         din_d      = arb.req_data[{win, 3'b000} +: 8];
      end
   end

   assign arb.busy      = (state_q == S_HOLD);
   assign arb.dbg_state = state_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: full-rate instance for frame timing, short-frame instance for
// arbitration tables and a randomized run against a grant/timing reference model.
`timescale 1ns/1ps
module tb_uart_tx_arb;
   localparam int HOLD_B = 4356;
   localparam int HOLD_S = 104;

   logic clk = 1'b0;
   logic rst_b, rst_s;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   uart_tx_arb_if #(.N_REQ(4)) bif ();
   uart_tx_arb_if #(.N_REQ(4)) sif ();

   uart_tx_arb #(.N_REQ(4), .CLK_FREQ(50000000), .UART_BPS(115200), .GUARD_CYC(16)) dut_b (
      .sys_clk(clk), .sys_rst(rst_b), .arb(bif.slave)
   );

   uart_tx_arb #(.N_REQ(4), .CLK_FREQ(1000), .UART_BPS(100), .GUARD_CYC(4)) dut_s (
      .sys_clk(clk), .sys_rst(rst_s), .arb(sif.slave)
   );

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] ack;
      logic [7:0] din;
   } vec_t;

   vec_t        tbl [8];
   logic [15:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic tmo(input string name);
      checks++;
      errors++;
      $display("FAIL %s: no uart_en within the cycle budget", name);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_grant_b(input string name, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!bif.uart_en && n < HOLD_B + 100);
      if (!bif.uart_en) tmo(name);
   endtask

   task automatic wait_grant_s(input string name, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!sif.uart_en && n < HOLD_S + 100);
      if (!sif.uart_en) tmo(name);
   endtask

   task automatic wait_idle_b;
      int n;
      n = 0;
      while (bif.busy && n < HOLD_B + 100) begin
         tick();
         n++;
      end
      chk("idle_b", 32'(bif.busy), 32'd0);
   endtask

   task automatic wait_idle_s;
      int n;
      n = 0;
      while (sif.busy && n < HOLD_S + 100) begin
         tick();
         n++;
      end
      chk("idle_s", 32'(sif.busy), 32'd0);
   endtask

   function automatic int pick(input logic [3:0] r, input int ptr);
      int w;
      w = -1;
`ifdef UART_ARB_FIXED_PRIO_EN
      for (int i = 3; i >= 0; i--) if (((r >> i) & 4'd1) != 4'd0) w = i;
`else
      for (int k = 3; k >= 0; k--) if (((r >> ((ptr + k) % 4)) & 4'd1) != 4'd0) w = (ptr + k) % 4;
`endif
      return w;
   endfunction

   initial begin
      int n, extra, e, m_last, m_ptr, w;
      logic       pred;
      logic [7:0] m_din, byte_v;
      logic [15:0] ent;
      int rr_exp [5];
      logic [3:0] ws_exp [3];
      logic [3:0] ff_exp [3];

`ifdef UART_ARB_FIXED_PRIO_EN
      rr_exp = '{0, 0, 0, 0, 0};
      ws_exp = '{4'b1000, 4'b0010, 4'b0010};
      ff_exp = '{4'b0010, 4'b0010, 4'b0010};
      tbl[0] = '{4'b0001, 4'b0001, 8'hA0};
      tbl[1] = '{4'b0001, 4'b0001, 8'hA0};
      tbl[2] = '{4'b1001, 4'b0001, 8'hA0};
      tbl[3] = '{4'b1010, 4'b0010, 8'hB1};
      tbl[4] = '{4'b1010, 4'b0010, 8'hB1};
      tbl[5] = '{4'b1100, 4'b0100, 8'hC2};
      tbl[6] = '{4'b0011, 4'b0001, 8'hA0};
      tbl[7] = '{4'b1111, 4'b0001, 8'hA0};
`else
      rr_exp = '{0, 1, 2, 3, 0};
      ws_exp = '{4'b1000, 4'b0010, 4'b0100};
      ff_exp = '{4'b1000, 4'b0010, 4'b1000};
      tbl[0] = '{4'b0001, 4'b0001, 8'hA0};
      tbl[1] = '{4'b0001, 4'b0001, 8'hA0};
      tbl[2] = '{4'b1001, 4'b1000, 8'hD3};
      tbl[3] = '{4'b1010, 4'b0010, 8'hB1};
      tbl[4] = '{4'b1010, 4'b1000, 8'hD3};
      tbl[5] = '{4'b1100, 4'b0100, 8'hC2};
      tbl[6] = '{4'b0011, 4'b0001, 8'hA0};
      tbl[7] = '{4'b1111, 4'b0010, 8'hB1};
`endif

      // Clock/reset
      bif.req = '0; bif.req_data = '0;
      sif.req = '0; sif.req_data = '0;
      rst_b = 1'b1; rst_s = 1'b1;
      tick(); tick(); tick();
      chk("rst_en",   32'(bif.uart_en),  32'd0);
      chk("rst_ack",  32'(bif.ack),      32'd0);
      chk("rst_din",  32'(bif.uart_din), 32'd0);
      chk("rst_busy", 32'(bif.busy),     32'd0);
      rst_b = 1'b0; rst_s = 1'b0;

      // Single request, busy length
      bif.req_data = {8'h33, 8'h5A, 8'h31, 8'h30};
      bif.req = 4'b0100;
      tick();
      chk("single_en",   32'(bif.uart_en),  32'd1);
      chk("single_ack",  32'(bif.ack),      32'(4'b0100));
      chk("single_din",  32'(bif.uart_din), 32'h5A);
      chk("single_busy", 32'(bif.busy),     32'd1);
      bif.req = '0;
      n = 0; extra = 0;
      while (bif.busy && n < HOLD_B + 100) begin
         n++;
         tick();
         if (bif.uart_en) extra++;
      end
      chk("single_busy_len", 32'(n), 32'(HOLD_B));
      chk("single_no_reen", 32'(extra), 32'd0);

      // Round-robin with all four requesting continuously
      rst_b = 1'b1; tick(); rst_b = 1'b0;
      bif.req_data = {8'h33, 8'h32, 8'h31, 8'h30};
      bif.req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         wait_grant_b("rr_wait", n);
         if (k > 0) chk("rr_gap", 32'(n), 32'(HOLD_B + 1));
         chk("rr_ack", 32'(bif.ack), 32'(1 << rr_exp[k]));
         chk("rr_din", 32'(bif.uart_din), 32'(8'h30 + rr_exp[k]));
      end
      bif.req = '0;

      // Wrap and skip
      wait_idle_b();
      bif.req = 4'b1000;
      wait_grant_b("ws_wait0", n);
      chk("ws_ack0", 32'(bif.ack), 32'(ws_exp[0]));
      bif.req = 4'b0110;
      for (int k = 1; k < 3; k++) begin
         wait_grant_b("ws_wait", n);
         chk("ws_gap", 32'(n), 32'(HOLD_B + 1));
         chk("ws_ack", 32'(bif.ack), 32'(ws_exp[k]));
      end
      bif.req = '0;

      // Late drop: req[0] stays up after ack, must not be re-served
      wait_idle_b();
      bif.req = 4'b0001;
      wait_grant_b("late_wait", n);
      chk("late_ack", 32'(bif.ack), 32'(4'b0001));
      repeat (5) tick();
      bif.req = '0;
      extra = 0;
      for (int c = 0; c < HOLD_B + 50; c++) begin
         tick();
         if (bif.uart_en) extra++;
      end
      chk("late_regrant", 32'(extra), 32'd0);
      chk("late_idle", 32'(bif.busy), 32'd0);

      // Reset mid-HOLD with a request held
      bif.req = 4'b0001;
      wait_grant_b("mid_wait", n);
      chk("mid_ack0", 32'(bif.ack), 32'(4'b0001));
      repeat (2000) tick();
      rst_b = 1'b1;
      tick();
      chk("mid_rst_en",   32'(bif.uart_en),  32'd0);
      chk("mid_rst_ack",  32'(bif.ack),      32'd0);
      chk("mid_rst_din",  32'(bif.uart_din), 32'd0);
      chk("mid_rst_busy", 32'(bif.busy),     32'd0);
      rst_b = 1'b0;
      tick();
      chk("mid_rel_en",   32'(bif.uart_en), 32'd1);
      chk("mid_rel_ack",  32'(bif.ack),     32'(4'b0001));
      chk("mid_rel_busy", 32'(bif.busy),    32'd1);
      bif.req = '0;

      // Arbitration table on the short-frame instance
      rst_s = 1'b1; tick(); rst_s = 1'b0;
      sif.req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      for (int v = 0; v < 8; v++) begin
         wait_idle_s();
         sif.req = tbl[v].req;
         tick();
         chk("tbl_en",  32'(sif.uart_en),  32'd1);
         chk("tbl_ack", 32'(sif.ack),      32'(tbl[v].ack));
         chk("tbl_din", 32'(sif.uart_din), 32'(tbl[v].din));
         sif.req = '0;
      end

      // Two requesters held continuously
      wait_idle_s();
      sif.req = 4'b1010;
      for (int k = 0; k < 3; k++) begin
         wait_grant_s("pair_wait", n);
         chk("pair_ack", 32'(sif.ack), 32'(ff_exp[k]));
      end
      sif.req = '0;
      extra = 0;
      for (int c = 0; c < HOLD_S + 10; c++) begin
         tick();
         if (sif.uart_en) extra++;
      end
      chk("pair_quiet", 32'(extra), 32'd0);

      // Randomized requesters against the reference model
      rst_s = 1'b1; tick(); rst_s = 1'b0;
      sif.req_data = '0;
      e = 0; m_last = -1000; m_ptr = 0; m_din = 8'h00; w = 0;
      for (int c = 0; c < 2200; c++) begin
         for (int i = 0; i < 4; i++) begin
            if (sif.ack[i]) begin
               if ($urandom_range(0, 1) == 1 && c < 2000) sif.req_data[8*i +: 8] = 8'($urandom);
               else sif.req[i] = 1'b0;
            end else if (!sif.req[i] && c < 2000 && $urandom_range(0, 20) == 0) begin
               sif.req[i] = 1'b1;
               sif.req_data[8*i +: 8] = 8'($urandom);
            end else if (sif.req[i] && $urandom_range(0, 199) == 0) begin
               sif.req[i] = 1'b0;
            end
         end
         if (c >= 2000) sif.req = '0;
         @(posedge clk);
         e++;
         pred = 1'b0;
         if (sif.req != '0 && (e - m_last) > HOLD_S) begin
            w = pick(sif.req, m_ptr);
            byte_v = sif.req_data[8*w +: 8];
            exp_q.push_back({8'(w), byte_v});
            m_din  = byte_v;
            m_last = e;
            m_ptr  = (w + 1) % 4;
            pred   = 1'b1;
         end
         #1;
         chk("rnd_en",   32'(sif.uart_en), 32'(pred));
         chk("rnd_ack",  32'(sif.ack), pred ? 32'(1 << w) : 32'd0);
         chk("rnd_busy", 32'(sif.busy), 32'((e - m_last) < HOLD_S));
         chk("rnd_din",  32'(sif.uart_din), 32'(m_din));
         if (sif.uart_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rnd_unexpected: uart_en with ack %0h, none expected", sif.ack);
            end else begin
               ent = exp_q.pop_front();
               chk("rnd_q_ack", 32'(sif.ack), 32'(1 << ent[15:8]));
               chk("rnd_q_din", 32'(sif.uart_din), 32'(ent[7:0]));
            end
         end
      end
      chk("rnd_q_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
